// File: rtl/register_file.sv
// 8 x 16-bit register file: two combinational read ports, one synchronous write port, R0 hardwired to zero.
// Optional write-through forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WD,
    input  logic              we,
    input  logic              clk,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              rst_n
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok;

    // R0 is never a legal destination, so its storage stays at the reset value.
    assign wr_ok = we && (RD != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[RD] <= WD;
        end
    end

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (RS != '0) begin
            RD1 = regs[RS];
        end
        if (RT != '0) begin
            RD2 = regs[RT];
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write; gated by rst_n so reset still reads as zero.
        if (rst_n && wr_ok && (RS == RD)) begin
            RD1 = WD;
        end
        if (rst_n && wr_ok && (RT == RD)) begin
            RD2 = WD;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default build and REGFILE_BYPASS_EN build).
module tb_register_file;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic [ADDR_W-1:0] RS, RT, RD;
    logic [DATA_W-1:0] WD;
    logic              we;
    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] RD1, RD2;

    int tests = 0;
    int fails = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .RS(RS), .RT(RT), .RD(RD), .WD(WD), .we(we),
        .clk(clk), .RD1(RD1), .RD2(RD2), .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic en);
        @(negedge clk);
        RD = a;
        WD = d;
        we = en;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        RS = '0; RT = '0; RD = '0; WD = '0; we = 1'b0;
        rst_n = 1'b0;

        // Reset held across an edge: every address reads zero on both ports.
        @(posedge clk);
        #2;
        for (int a = 0; a < 8; a++) begin
            RS = ADDR_W'(a);
            RT = ADDR_W'(7 - a);
            #1;
            check($sformatf("reset_rd1_r%0d", a), RD1, 16'd0);
            check($sformatf("reset_rd2_r%0d", 7 - a), RD2, 16'd0);
        end

        @(negedge clk);
        rst_n = 1'b1;

        write_reg(3'd5, 16'd100, 1'b1);
        write_reg(3'd6, 16'd101, 1'b1);
        RS = 3'd5; RT = 3'd6; #1;
        check("wr_r5", RD1, 16'd100);
        check("wr_r6", RD2, 16'd101);
        RS = 3'd0; RT = 3'd6; #1;
        check("rs0_rd1", RD1, 16'd0);
        check("rs0_rd2", RD2, 16'd101);
        RS = 3'd5; RT = 3'd0; #1;
        check("rt0_rd1", RD1, 16'd100);
        check("rt0_rd2", RD2, 16'd0);
        RS = 3'd6; RT = 3'd6; #1;
        check("same_addr_rd1", RD1, 16'd101);
        check("same_addr_rd2", RD2, 16'd101);

        // Write to R0 is discarded; other registers untouched.
        write_reg(3'd0, 16'hFFFF, 1'b1);
        RS = 3'd0; RT = 3'd5; #1;
        check("r0_write_rd1", RD1, 16'd0);
        check("r0_write_r5", RD2, 16'd100);
        RS = 3'd6; RT = 3'd0; #1;
        check("r0_write_r6", RD1, 16'd101);
        check("r0_write_rd2", RD2, 16'd0);

        // we=0 leaves contents alone.
        write_reg(3'd5, 16'd555, 1'b0);
        RS = 3'd5; #1;
        check("we0_r5", RD1, 16'd100);

        // Read-during-write on R7 (currently 0).
        @(negedge clk);
        RS = 3'd7; RD = 3'd7; WD = 16'd77; we = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_edge", RD1, 16'd77);
`else
        check("rdw_before_edge", RD1, 16'd0);
`endif
        @(posedge clk);
        #1;
        we = 1'b0;
        check("rdw_after_edge", RD1, 16'd77);

        // Asynchronous reset mid-cycle, away from any edge, with a write pending.
        @(negedge clk);
        RS = 3'd5; RT = 3'd6;
        RD = 3'd4; WD = 16'hBEEF; we = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", RD1, 16'd0);
        check("async_rst_rd2", RD2, 16'd0);
        RS = 3'd7; RT = 3'd4; #1;
        check("async_rst_r7", RD1, 16'd0);
        check("async_rst_r4_fwd", RD2, 16'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("rst_wins_r4", RD2, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;
        write_reg(3'd3, 16'h1234, 1'b1);
        RS = 3'd3; RT = 3'd4; #1;
        check("post_rst_r3", RD1, 16'h1234);
        check("post_rst_r4", RD2, 16'd0);
        RS = 3'd5; RT = 3'd7; #1;
        check("post_rst_r5", RD1, 16'd0);
        check("post_rst_r7", RD2, 16'd0);

        // Full-width data pattern on the highest register.
        write_reg(3'd7, 16'hA5C3, 1'b1);
        RS = 3'd7; RT = 3'd3; #1;
        check("r7_pattern", RD1, 16'hA5C3);
        check("r3_kept", RD2, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
